// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: access sizes, FSM states
// and small size-decoding helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [2:0] size_bytes(size_e s);
    case (s)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(size_e s);
    case (s)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory
// controller (slave).
interface data_memory_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/mem_byte_array.sv
// Four independent byte lanes of WORDS entries each; synchronous per-lane
// write, combinational read. Contents are intentionally not reset.
module mem_byte_array #(
  parameter int unsigned WORDS = 256,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] word_idx,
  input  logic [3:0]       byte_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [WORDS];

    always_ff @(posedge clk) begin
      if (byte_en[g]) lane_mem[word_idx] <= wdata[8*g +: 8];
    end

    assign rdata[8*g +: 8] = lane_mem[word_idx];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory controller with valid/ready
// handshake, programmable wait states and bad-access error reporting.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_ctrl_if.slave bus
);

  localparam int unsigned WORDS = DEPTH_BYTES / 4;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state, next_state;
  logic [3:0]        wait_cnt;
  logic              lat_write, lat_unsigned;
  size_e             lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              error_q;

  logic              accept, commit;
  logic              misaligned, out_of_range, access_err;
  logic [ADDR_W:0]   end_addr;
  logic [1:0]        offset;
  logic [4:0]        shamt;
  logic [3:0]        byte_en;
  logic [31:0]       lane_wdata, lane_rdata, shifted, load_data;
  logic [IDX_W-1:0]  word_idx;

  assign accept          = bus.req_valid && (state == IDLE);
  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_error  = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) next_state = BUSY;
      BUSY: if (wait_cnt == 4'd0) begin
        commit     = 1'b1;
        next_state = RESP;
      end
      RESP: if (bus.resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Range check uses the full latched address, so high address bits never alias.
  always_comb begin
    offset       = lat_addr[1:0];
    shamt        = {offset, 3'b000};
    end_addr     = {1'b0, lat_addr} + (ADDR_W+1)'(size_bytes(lat_size));
    out_of_range = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
    misaligned   = ((lat_size == SIZE_HALF) && offset[0]) ||
                   ((lat_size == SIZE_WORD) && (offset != 2'd0));
    access_err   = misaligned || out_of_range || (lat_size == SIZE_RSVD);
    word_idx     = lat_addr[IDX_W+1:2];
    byte_en      = (commit && lat_write && !access_err) ? (lane_mask(lat_size) << offset) : '0;
    lane_wdata   = lat_wdata << shamt;
    shifted      = lane_rdata >> shamt;
    case (lat_size)
      SIZE_BYTE: load_data = {{24{!lat_unsigned && shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{!lat_unsigned && shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= SIZE_BYTE;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt     <= 4'(WAIT_STATES);
        lat_write    <= bus.req_write;
        lat_unsigned <= bus.req_unsigned;
        lat_size     <= size_e'(bus.req_size);
        lat_addr     <= bus.req_addr;
        lat_wdata    <= bus.req_wdata;
      end else if ((state == BUSY) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (commit) begin
        error_q <= access_err;
        rdata_q <= (access_err || lat_write) ? '0 : load_data;
      end
    end
  end

  mem_byte_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .word_idx (word_idx),
    .byte_en  (byte_en),
    .wdata    (lane_wdata),
    .rdata    (lane_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed, table-driven bench for data_memory_ctrl (WAIT_STATES=3, 1 KiB).
module tb_data_memory_ctrl;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned WAIT   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_memory_ctrl #(
    .ADDR_W      (ADDR_W),
    .DEPTH_BYTES (DEPTH),
    .WAIT_STATES (WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic         w;
    logic [1:0]   sz;
    logic         u;
    logic [17:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  exp_rd;
    logic         exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic w, input logic [1:0] sz, input logic u,
                     input logic [17:0] a, input logic [31:0] d, input logic [31:0] rd,
                     input logic er);
    vec_t v;
    v.name = n; v.w = w; v.sz = sz; v.u = u; v.addr = a; v.wdata = d;
    v.exp_rd = rd; v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request; returns at RESP (auto_ack=0) or after the response handshake.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [17:0] a, input logic [31:0] d, input bit auto_ack,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~w; bus.req_size = 2'b11; bus.req_addr = '0; bus.req_wdata = '1;
    lat = 0;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_error;
    if (auto_ack) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b1;

    add("st_w_10",      1, 2'b10, 0, 18'h00010, 32'hDEADBEEF, 32'h00000000, 0);
    add("st_w_14",      1, 2'b10, 0, 18'h00014, 32'h00000000, 32'h00000000, 0);
    add("ld_w_10",      0, 2'b10, 0, 18'h00010, 32'h0,        32'hDEADBEEF, 0);
    add("ld_bs_13",     0, 2'b00, 0, 18'h00013, 32'h0,        32'hFFFFFFDE, 0);
    add("ld_bu_13",     0, 2'b00, 1, 18'h00013, 32'h0,        32'h000000DE, 0);
    add("ld_hs_12",     0, 2'b01, 0, 18'h00012, 32'h0,        32'hFFFFDEAD, 0);
    add("ld_hu_10",     0, 2'b01, 1, 18'h00010, 32'h0,        32'h0000BEEF, 0);
    add("ld_hs_10",     0, 2'b01, 0, 18'h00010, 32'h0,        32'hFFFFBEEF, 0);
    add("ld_bs_11",     0, 2'b00, 0, 18'h00011, 32'h0,        32'hFFFFFFBE, 0);
    add("ld_wu_10",     0, 2'b10, 1, 18'h00010, 32'h0,        32'hDEADBEEF, 0);
    add("st_b_11",      1, 2'b00, 0, 18'h00011, 32'hAAAAAA55, 32'h00000000, 0);
    add("ld_w_10b",     0, 2'b10, 0, 18'h00010, 32'h0,        32'hDEAD55EF, 0);
    add("st_h_16",      1, 2'b01, 0, 18'h00016, 32'h99997E01, 32'h00000000, 0);
    add("ld_w_14",      0, 2'b10, 0, 18'h00014, 32'h0,        32'h7E010000, 0);
    add("ld_hs_16",     0, 2'b01, 0, 18'h00016, 32'h0,        32'h00007E01, 0);
    add("ld_h_11_err",  0, 2'b01, 0, 18'h00011, 32'h0,        32'h00000000, 1);
    add("st_w_12_err",  1, 2'b10, 0, 18'h00012, 32'h11111111, 32'h00000000, 1);
    add("ld_w_10c",     0, 2'b10, 0, 18'h00010, 32'h0,        32'hDEAD55EF, 0);
    add("ld_w_14c",     0, 2'b10, 0, 18'h00014, 32'h0,        32'h7E010000, 0);
    add("ld_rsvd_err",  0, 2'b11, 0, 18'h00010, 32'h0,        32'h00000000, 1);
    add("st_rsvd_err",  1, 2'b11, 0, 18'h00010, 32'h00000000, 32'h00000000, 1);
    add("ld_w_10d",     0, 2'b10, 0, 18'h00010, 32'h0,        32'hDEAD55EF, 0);
    add("st_w_3fc",     1, 2'b10, 0, 18'h003FC, 32'hA5A5C3C3, 32'h00000000, 0);
    add("ld_w_3fe_err", 0, 2'b10, 0, 18'h003FE, 32'h0,        32'h00000000, 1);
    add("ld_hu_3fe",    0, 2'b01, 1, 18'h003FE, 32'h0,        32'h0000A5A5, 0);
    add("ld_bs_3ff",    0, 2'b00, 0, 18'h003FF, 32'h0,        32'hFFFFFFA5, 0);
    add("ld_b_400_err", 0, 2'b00, 0, 18'h00400, 32'h0,        32'h00000000, 1);
    add("st_b_400_err", 1, 2'b00, 0, 18'h00400, 32'h00000077, 32'h00000000, 1);
    add("ld_w_hi_err",  0, 2'b10, 0, 18'h20010, 32'h0,        32'h00000000, 1);
    add("st_w_hi_err",  1, 2'b10, 0, 18'h20010, 32'h00000000, 32'h00000000, 1);
    add("ld_w_10e",     0, 2'b10, 0, 18'h00010, 32'h0,        32'hDEAD55EF, 0);
    add("ld_w_3fc",     0, 2'b10, 0, 18'h003FC, 32'h0,        32'hA5A5C3C3, 0);

    // reset values, both while asserted and just after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,           32'd0);
    chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].addr, vecs[i].wdata, 1'b1, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_error"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(1 + WAIT));
    end

    // response back-pressure: outputs frozen, no new request accepted
    bus.resp_ready = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0, 1'b0, rd, er, lat);
    chk("bp_lat", 32'(lat), 32'(1 + WAIT));
    for (int c = 0; c < 5; c++) begin
      chk("bp_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'hDEAD55EF);
      chk("bp_req_ready",  {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);

    // reset during BUSY discards the pending store
    do_req(1'b1, 2'b10, 1'b0, 18'h00020, 32'hCAFEF00D, 1'b1, rd, er, lat);
    do_req(1'b0, 2'b10, 1'b0, 18'h00020, 32'h0, 1'b1, rd, er, lat);
    chk("pre_rst_ld_20", rd, 32'hCAFEF00D);
    bus.req_write = 1'b1; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 18'h00020; bus.req_wdata = 32'h12345678; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("busy_req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  {31'd0, bus.req_ready},  32'd1);
    chk("mid_rst_valid",  {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_rst_rdata",  bus.resp_rdata,           32'd0);
    chk("mid_rst_error",  {31'd0, bus.resp_error}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_hold_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 2'b10, 1'b0, 18'h00020, 32'h0, 1'b1, rd, er, lat);
    chk("post_rst_ld_20", rd, 32'hCAFEF00D);
    chk("post_rst_ld_20_err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
